// File: rtl/truth_table_sweeper.sv
// Walks a four-input logic stage through all 16 input vectors, in auto or manual mode,
// and records the stage's three outputs per vector in a 48-bit truth table.
module truth_table_sweeper #(
    parameter int unsigned DWELL    = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        auto,
    input  logic        step_btn,
    input  logic        res1,
    input  logic        res2,
    input  logic        res3,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic [3:0]  idx,
    output logic [47:0] table_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [47:0] table_q, table_d;
    logic [7:0]  dwell_q, dwell_d;
    logic        mode_q, mode_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        db_level_q, db_level_d;
    logic [7:0]  db_cnt_q, db_cnt_d;
    logic        step_q, step_d;

    // Button path: 2-flop synchronizer, stability counter, rising-edge pulse.
    always_comb begin
        sync1_d    = step_btn;
        sync2_d    = sync1_q;
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DEB_LAST) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end
        step_d = db_level_d & ~db_level_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        table_d = table_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_APPLY;
                    idx_d   = '0;
                    table_d = '0;
                    mode_d  = auto;
                    dwell_d = '0;
                end
            end
            S_APPLY: begin
                if (mode_q) begin
                    if (dwell_q == DWELL_LAST) begin
                        state_d = S_CAPTURE;
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end else if (step_q) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                for (int i = 0; i < 16; i++) begin
                    if (idx_q == 4'(i)) begin
                        table_d[3*i +: 3] = {res1, res2, res3};
                    end
                end
                if (idx_q == 4'd15) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_APPLY;
                    idx_d   = idx_q + 4'd1;
                    dwell_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_APPLY) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            table_q    <= '0;
            dwell_q    <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            table_q    <= table_d;
            dwell_q    <= dwell_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            step_q     <= step_d;
        end
    end

    assign {a, b, c, d} = idx_q;
    assign idx          = idx_q;
    assign table_out    = table_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: reset, auto sweep, manual stepping,
// start handling, mid-sweep reset and end-of-sweep behaviour.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n, start, auto, step_btn;
    logic        res1, res2, res3;
    logic        a, b, c, d;
    logic [3:0]  idx;
    logic [47:0] table_out;
    logic        busy, done;

    int tests = 0;
    int fails = 0;

    truth_table_sweeper #(.DWELL(4), .DEBOUNCE(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .auto(auto), .step_btn(step_btn),
        .res1(res1), .res2(res2), .res3(res3),
        .a(a), .b(b), .c(c), .d(d), .idx(idx), .table_out(table_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream logic stage: {res1,res2,res3} = f(a,b,c,d).
    function automatic logic [2:0] stage(input logic [3:0] v);
        logic r1, r2, r3;
        r1 = v[3] ^ v[2] ^ v[1] ^ v[0];
        r2 = (v[3] & v[2]) | (v[1] & v[0]);
        r3 = ~v[3] & (v[2] | v[0]);
        return {r1, r2, r3};
    endfunction

    assign {res1, res2, res3} = stage({a, b, c, d});

    function automatic logic [47:0] exp_table(input int n);
        logic [47:0] t;
        t = '0;
        for (int i = 0; i < n; i++) t[3*i +: 3] = stage(4'(i));
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_status"}, 48'({idx, a, b, c, d, busy, done}), 48'd0);
        check({tag, "_table"}, table_out, 48'd0);
    endtask

    task automatic press(input int high_cycles);
        step_btn = 1'b1;
        repeat (high_cycles) tick();
        step_btn = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        auto     = 1'b1;
        step_btn = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_all_zero("reset_hold");
        end
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check_all_zero("idle_after_reset");

        // Auto sweep: each vector held 5 cycles, done exactly 80 edges after start.
        start = 1'b1;
        auto  = 1'b1;
        tick();
        start = 1'b0;
        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < 5; k++) begin
                check("auto_vec", 48'({a, b, c, d}), 48'(v));
                check("auto_busy_done", 48'({busy, done}), 48'b10);
                tick();
            end
        end
        check("auto_done", 48'({busy, done}), 48'b01);
        check("auto_idx_end", 48'({idx, a, b, c, d}), 48'hFF);
        check("auto_table", table_out, exp_table(16));

        // In DONE: button presses and idle time must not disturb the table.
        press(15);
        repeat (100) tick();
        check("done_frozen_table", table_out, exp_table(16));
        check("done_frozen_status", 48'({idx, a, b, c, d, busy, done}), 48'({4'hF, 4'hF, 2'b01}));

        // Restart from DONE in manual mode.
        start = 1'b1;
        auto  = 1'b0;
        tick();
        start = 1'b0;
        check("restart_table", table_out, 48'd0);
        check("restart_status", 48'({idx, busy, done}), 48'({4'h0, 2'b10}));

        // First press: idx moves exactly DEBOUNCE+4 = 7 edges after the button edge.
        step_btn = 1'b1;
        repeat (6) tick();
        check("manual_latency_before", 48'(idx), 48'd0);
        tick();
        check("manual_latency_after", 48'(idx), 48'd1);
        repeat (5) tick();
        step_btn = 1'b0;
        repeat (12) tick();
        check("manual_table_v0", table_out, exp_table(1));

        press(12);
        press(12);
        check("manual_three_presses", 48'({idx, busy, done}), 48'({4'd3, 2'b10}));

        step_btn = 1'b1;
        repeat (2) tick();
        step_btn = 1'b0;
        repeat (15) tick();
        check("manual_glitch", 48'(idx), 48'd3);

        press(50);
        check("manual_long_hold", 48'(idx), 48'd4);
        check("manual_table_v3", table_out, exp_table(4));

        // start while busy is ignored.
        press(12);
        check("manual_idx5", 48'(idx), 48'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_ignored", 48'({idx, busy, done}), 48'({4'd5, 2'b10}));
        check("busy_start_table", table_out, exp_table(5));
        repeat (10) tick();
        check("busy_start_hold", 48'(idx), 48'd5);
        press(12);
        check("busy_start_continue", 48'(idx), 48'd6);

        // Reset, then an auto sweep aborted by reset at idx=7.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("manual_abort");
        start = 1'b1;
        auto  = 1'b1;
        tick();
        start = 1'b0;
        repeat (36) tick();
        check("auto_at_idx7", 48'({idx, busy}), 48'({4'd7, 1'b1}));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("mid_sweep_reset");
        repeat (20) tick();
        check_all_zero("post_reset_quiet");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that sits directly upstream of the four-input combinational logic stage. It drives that stage's inputs a, b, c and d through all 16 combinations, in order, either automatically or one board button press at a time. At each vector it captures the stage's three outputs into a 48-bit truth-table register. It reports busy/done so the board display or a testbench can read the finished table.

## Interface
Parameters:
- DWELL, 4: cycles each vector is held in auto mode before capture; legal range 1..255.
- DEBOUNCE, 3: consecutive stable cycles needed to accept a new step_btn level; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin a sweep; sampled in IDLE and DONE only.
- auto  input  1  1 = auto-advance, 0 = manual step; latched when start is accepted.
- step_btn  input  1  raw, asynchronous push-button; advances the sweep in manual mode.
- res1, res2, res3  input  1 each  outputs of the downstream logic stage.
- a, b, c, d  output  1 each  vector driven to the logic stage: {a,b,c,d} = idx.
- idx  output  4  current vector index.
- table_out  output  48  bits [3i+2:3i] = {res1,res2,res3} captured for vector i.
- busy  output  1  high in APPLY and CAPTURE.
- done  output  1  high in DONE.

## Operation
- All outputs are registered.
- Reset: rst_n low at a clk edge forces the following, which hold while rst_n stays low:
  - state IDLE, idx=0, a..d=0;
  - table_out=0, busy=0, done=0;
  - dwell counter 0, debouncer state cleared.
- Reset mid-sweep aborts the sweep with no partial result retained.
- FSM states: IDLE, APPLY, CAPTURE, DONE.
  - IDLE: start=1 → APPLY. On that edge: idx=0, table_out cleared, mode latched from auto, dwell counter cleared.
  - APPLY, auto mode: counter increments each cycle. When counter==DWELL-1 → CAPTURE.
  - APPLY, manual mode: a debounced step pulse → CAPTURE. With no pulse, APPLY holds indefinitely.
  - CAPTURE (1 cycle): on its exit edge, table_out[3·idx+2 : 3·idx] is loaded with {res1,res2,res3}.
    - If idx==15 → DONE, idx held at 15.
    - Otherwise idx+1 → APPLY, counter cleared.
  - DONE: done=1 and table_out frozen. a..d hold 1111. start=1 restarts exactly as from IDLE, and done drops on that edge.
- start in APPLY or CAPTURE is ignored. auto changes mid-sweep are ignored.
- Step debouncer:
  - step_btn passes through a 2-flop synchronizer.
  - The debounced level changes only after the synchronized value has differed from it for DEBOUNCE consecutive cycles.
  - A rising edge of the debounced level produces a one-cycle step pulse.
  - Step pulses outside manual APPLY are discarded, not queued.
- idx arithmetic is 4-bit. It never wraps within a sweep; DONE terminates at 15.

## Timing
- Start accepted at edge E0 → busy=1 and {a,b,c,d}=0000 visible after E0.
- Auto mode, per vector:
  - DWELL cycles in APPLY, then 1 cycle in CAPTURE.
  - res sampled DWELL+1 edges after the vector is applied. The downstream stage therefore gets at least DWELL cycles to settle.
- Auto sweep length: done=1 and busy=0 after edge E0 + 16·(DWELL+1). With DWELL=4, that is 80 cycles.
- Manual mode, button-to-pulse latency: 2 synchronizer cycles + DEBOUNCE cycles, then 1 cycle to CAPTURE, then idx updates on the next edge.
  - Total: DEBOUNCE+4 edges from the button edge to the new idx.
- Table bits for vector i become valid on the CAPTURE exit edge for vector i. Later vectors never modify them.
- Simultaneous events:
  - rst_n low overrides start and step.
  - start and a step pulse in the same DONE cycle: restart only; the step is discarded.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1 → idx=0, a..d=0, table_out=0, busy=0, done=0 throughout.
- Auto sweep: DWELL=4, res driven by a bench model of the logic stage, one-cycle start with auto=1.
  - {a,b,c,d} steps 0000→1111, each value held 5 cycles.
  - done=1 exactly 80 cycles after the start edge.
  - table_out matches the model for all 16 vectors.
- Manual stepping: DEBOUNCE=3, auto=0, three clean presses, each high ≥10 cycles → idx=3 and busy=1.
  - A 2-cycle glitch on step_btn → idx unchanged.
  - Holding the button for 50 cycles → exactly one advance.
- Start handling:
  - start pulsed while busy at idx=5 → no effect, sweep continues.
  - start in DONE → table_out=0, done=0, idx=0 on the next edge.
- Mid-sweep reset: rst_n low for one cycle at idx=7 in auto mode → IDLE, all outputs 0. No further activity until start.
- End boundary: after vector 15 is captured → idx stays 15, a..d=1111, done=1.
  - Further step presses and 100 idle cycles leave table_out unchanged.
